// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: slot storage, match arbitration, ring/snooze FSM.
// Optional macro ALARM_PENDING_EN keeps losing/late matches queued as pending.
module alarm_scheduler #(
    parameter int NUM_SLOTS  = 4,
    parameter int SLOT_W     = 2,
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic              clk_1s,
    input  logic              reset,
    input  logic [1:0]        tm_h1,
    input  logic [3:0]        tm_h0,
    input  logic [3:0]        tm_m1,
    input  logic [3:0]        tm_m0,
    input  logic [3:0]        tm_s1,
    input  logic [3:0]        tm_s0,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [1:0]        wr_h1,
    input  logic [3:0]        wr_h0,
    input  logic [3:0]        wr_m1,
    input  logic [3:0]        wr_m0,
    input  logic              wr_arm,
    input  logic              al_on,
    input  logic              stop_al,
    input  logic              snooze,
    output logic              alarm,
    output logic [SLOT_W-1:0] active_slot,
    output logic [1:0]        state,
    output logic [11:0]       remain
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RING   = 2'b01,
        S_SNOOZE = 2'b10
    } st_t;

    localparam logic [11:0] RING_LD = 12'(RING_SEC - 1);
    localparam logic [11:0] SNZ_LD  = 12'(SNOOZE_SEC - 1);
    localparam logic [2:0]  SNZ_MAX = 3'(MAX_SNOOZE);

    logic [1:0]           sl_h1 [NUM_SLOTS];
    logic [3:0]           sl_h0 [NUM_SLOTS];
    logic [3:0]           sl_m1 [NUM_SLOTS];
    logic [3:0]           sl_m0 [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] sl_arm;

    st_t               st_q, st_d;
    logic              alarm_q, alarm_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [11:0]       rem_q, rem_d;
    logic [2:0]        cnt_q, cnt_d;

    logic [NUM_SLOTS-1:0] match;
    logic                 any_match;
    logic [SLOT_W-1:0]    winner;
    logic                 on_top;

    // Slot storage; out-of-range indices simply never hit the compare.
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                sl_h1[i] <= '0;
                sl_h0[i] <= '0;
                sl_m1[i] <= '0;
                sl_m0[i] <= '0;
            end
            sl_arm <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_en && wr_slot == SLOT_W'(i)) begin
                    sl_h1[i]  <= wr_h1;
                    sl_h0[i]  <= wr_h0;
                    sl_m1[i]  <= wr_m1;
                    sl_m0[i]  <= wr_m0;
                    sl_arm[i] <= wr_arm;
                end
            end
        end
    end

    assign on_top = (tm_s1 == 4'd0) && (tm_s0 == 4'd0);

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            match[i] = sl_arm[i] && on_top
                    && tm_h1 == sl_h1[i] && tm_h0 == sl_h0[i]
                    && tm_m1 == sl_m1[i] && tm_m0 == sl_m0[i];
        end
    end

    assign any_match = |match;

    always_comb begin
        winner = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (match[i]) winner = SLOT_W'(i);
        end
    end

`ifdef ALARM_PENDING_EN
    logic [NUM_SLOTS-1:0] pend_q, pend_d;
    logic [NUM_SLOTS-1:0] disarm;
    logic                 any_pend;
    logic [SLOT_W-1:0]    pend_win;

    always_comb begin
        disarm = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            disarm[i] = wr_en && !wr_arm && wr_slot == SLOT_W'(i);
        end
    end

    assign any_pend = |pend_q;

    always_comb begin
        pend_win = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pend_q[i]) pend_win = SLOT_W'(i);
        end
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end
`endif

    always_comb begin
        st_d    = st_q;
        alarm_d = alarm_q;
        slot_d  = slot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
`ifdef ALARM_PENDING_EN
        pend_d  = pend_q;
`endif
        if (!al_on) begin
            st_d    = S_IDLE;
            alarm_d = 1'b0;
            rem_d   = '0;
`ifdef ALARM_PENDING_EN
            pend_d  = '0;
`endif
        end else begin
            unique case (st_q)
                S_IDLE: begin
                    rem_d = '0;
                    if (any_match) begin
                        st_d    = S_RING;
                        alarm_d = 1'b1;
                        slot_d  = winner;
                        rem_d   = RING_LD;
                        cnt_d   = '0;
`ifdef ALARM_PENDING_EN
                        pend_d  = pend_q | (match & ~(NUM_SLOTS'(1) << winner));
                    end else if (any_pend) begin
                        st_d    = S_RING;
                        alarm_d = 1'b1;
                        slot_d  = pend_win;
                        rem_d   = RING_LD;
                        cnt_d   = '0;
                        pend_d  = pend_q & ~(NUM_SLOTS'(1) << pend_win);
`endif
                    end
                end
                S_RING: begin
                    if (stop_al) begin
                        st_d    = S_IDLE;
                        alarm_d = 1'b0;
                        rem_d   = '0;
                    end else if (snooze && cnt_q < SNZ_MAX) begin
                        st_d    = S_SNOOZE;
                        alarm_d = 1'b0;
                        rem_d   = SNZ_LD;
                        cnt_d   = cnt_q + 3'd1;
                    end else if (rem_q == 12'd0) begin
                        st_d    = S_IDLE;
                        alarm_d = 1'b0;
                    end else begin
                        rem_d = rem_q - 12'd1;
                    end
`ifdef ALARM_PENDING_EN
                    pend_d = pend_q | match;
`endif
                end
                S_SNOOZE: begin
                    if (stop_al) begin
                        st_d    = S_IDLE;
                        alarm_d = 1'b0;
                        rem_d   = '0;
                    end else if (rem_q == 12'd0) begin
                        st_d    = S_RING;
                        alarm_d = 1'b1;
                        rem_d   = RING_LD;
                    end else begin
                        rem_d = rem_q - 12'd1;
                    end
`ifdef ALARM_PENDING_EN
                    pend_d = pend_q | match;
`endif
                end
                default: begin
                    st_d    = S_IDLE;
                    alarm_d = 1'b0;
                    rem_d   = '0;
                end
            endcase
        end
`ifdef ALARM_PENDING_EN
        pend_d = pend_d & ~disarm;
`endif
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            st_q    <= S_IDLE;
            alarm_q <= 1'b0;
            slot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            alarm_q <= alarm_d;
            slot_q  <= slot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alarm       = alarm_q;
    assign active_slot = slot_q;
    assign state       = st_q;
    assign remain      = rem_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed self-checking bench for alarm_scheduler (default parameters).
module tb_alarm_scheduler;

    logic       clk_1s = 1'b0;
    logic       reset;
    logic [1:0] tm_h1;
    logic [3:0] tm_h0, tm_m1, tm_m0, tm_s1, tm_s0;
    logic       wr_en;
    logic [1:0] wr_slot;
    logic [1:0] wr_h1;
    logic [3:0] wr_h0, wr_m1, wr_m0;
    logic       wr_arm, al_on, stop_al, snooze;
    logic       alarm;
    logic [1:0] active_slot;
    logic [1:0] state;
    logic [11:0] remain;

    int n_chk = 0;
    int n_err = 0;

    alarm_scheduler dut (
        .clk_1s(clk_1s), .reset(reset),
        .tm_h1(tm_h1), .tm_h0(tm_h0), .tm_m1(tm_m1),
        .tm_m0(tm_m0), .tm_s1(tm_s1), .tm_s0(tm_s0),
        .wr_en(wr_en), .wr_slot(wr_slot),
        .wr_h1(wr_h1), .wr_h0(wr_h0), .wr_m1(wr_m1), .wr_m0(wr_m0),
        .wr_arm(wr_arm), .al_on(al_on), .stop_al(stop_al), .snooze(snooze),
        .alarm(alarm), .active_slot(active_slot), .state(state), .remain(remain)
    );

    always #5 clk_1s = ~clk_1s;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1s);
        #1;
    endtask

    task automatic set_time(input int h1, input int h0, input int m1,
                            input int m0, input int s1, input int s0);
        tm_h1 = 2'(h1); tm_h0 = 4'(h0); tm_m1 = 4'(m1);
        tm_m0 = 4'(m0); tm_s1 = 4'(s1); tm_s0 = 4'(s0);
    endtask

    task automatic prog(input int slot, input int h1, input int h0,
                        input int m1, input int m0, input logic arm);
        wr_en = 1'b1; wr_slot = 2'(slot);
        wr_h1 = 2'(h1); wr_h0 = 4'(h0); wr_m1 = 4'(m1); wr_m0 = 4'(m0);
        wr_arm = arm;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int a, input int st,
                           input int rem);
        chk({tag, ".alarm"}, int'(alarm), a);
        chk({tag, ".state"}, int'(state), st);
        chk({tag, ".remain"}, int'(remain), rem);
    endtask

    initial begin
        reset = 1'b1;
        set_time(0, 0, 0, 0, 0, 1);
        wr_en = 0; wr_slot = 0; wr_h1 = 0; wr_h0 = 0; wr_m1 = 0; wr_m0 = 0;
        wr_arm = 0; al_on = 0; stop_al = 0; snooze = 0;
        #2;
        chk_out("rst", 0, 0, 0);
        chk("rst.slot", int'(active_slot), 0);
        #10 reset = 1'b0;
        al_on = 1'b1;

        // Basic ring and full timeout
        prog(0, 0, 7, 3, 0, 1'b1);
        set_time(0, 7, 2, 9, 5, 9);
        tick();
        chk_out("pre", 0, 0, 0);
        set_time(0, 7, 3, 0, 0, 0);
        tick();
        chk_out("ring", 1, 1, 59);
        chk("ring.slot", int'(active_slot), 0);
        set_time(0, 7, 3, 0, 0, 1);
        for (int k = 58; k >= 0; k--) begin
            tick();
            chk("cnt.remain", int'(remain), k);
        end
        chk("cnt.alarm", int'(alarm), 1);
        tick();
        chk_out("tmo", 0, 0, 0);

        // Rewrite active slot mid-ring, then stop beats snooze
        set_time(0, 7, 3, 0, 0, 0);
        tick();
        set_time(0, 7, 3, 0, 0, 1);
        prog(0, 0, 8, 0, 0, 1'b1);
        chk_out("wract", 1, 1, 58);
        prog(0, 0, 7, 3, 0, 1'b1);
        stop_al = 1; snooze = 1;
        tick();
        stop_al = 0; snooze = 0;
        chk_out("stopsnz", 0, 0, 0);

        // Three snoozes, fourth ignored
        set_time(0, 7, 3, 0, 0, 0);
        tick();
        set_time(0, 7, 3, 0, 0, 1);
        chk_out("s.ring", 1, 1, 59);
        for (int r = 0; r < 3; r++) begin
            snooze = 1;
            tick();
            snooze = 0;
            chk_out("s.enter", 0, 2, 299);
            snooze = 1;
            tick();
            snooze = 0;
            chk_out("s.inside", 0, 2, 298);
            repeat (298) tick();
            chk_out("s.end", 0, 2, 0);
            tick();
            chk_out("s.rering", 1, 1, 59);
        end
        snooze = 1;
        tick();
        snooze = 0;
        chk_out("s.4th", 1, 1, 58);
        repeat (58) tick();
        chk_out("s.last", 1, 1, 0);
        tick();
        chk_out("s.tmo", 0, 0, 0);

        // Simultaneous match: lowest slot wins
        prog(1, 0, 6, 0, 0, 1'b1);
        prog(2, 0, 6, 0, 0, 1'b1);
        set_time(0, 6, 0, 0, 0, 0);
        tick();
        set_time(0, 6, 0, 0, 0, 1);
        chk_out("arb", 1, 1, 59);
        chk("arb.slot", int'(active_slot), 1);
        stop_al = 1;
        tick();
        stop_al = 0;
        chk_out("arb.stop", 0, 0, 0);
        tick();
`ifdef ALARM_PENDING_EN
        chk_out("arb.pend", 1, 1, 59);
        chk("arb.pslot", int'(active_slot), 2);
        stop_al = 1;
        tick();
        stop_al = 0;
        tick();
`endif
        chk_out("arb.after", 0, 0, 0);

        // al_on drop mid-ring and disabled match
        set_time(0, 7, 3, 0, 0, 0);
        tick();
        set_time(0, 7, 3, 0, 0, 1);
        chk("off.pre", int'(alarm), 1);
        al_on = 0;
        tick();
        chk_out("off", 0, 0, 0);
        prog(3, 1, 2, 0, 0, 1'b1);
        set_time(1, 2, 0, 0, 0, 0);
        tick();
        chk_out("off.match", 0, 0, 0);
        al_on = 1;
        set_time(1, 2, 0, 0, 0, 1);
        tick();
        chk_out("on.nomatch", 0, 0, 0);

        // Reset during snooze clears state and slots
        set_time(1, 2, 0, 0, 0, 0);
        tick();
        set_time(1, 2, 0, 0, 0, 1);
        chk("r.slot", int'(active_slot), 3);
        snooze = 1;
        tick();
        snooze = 0;
        chk_out("r.snz", 0, 2, 299);
        #2 reset = 1'b1;
        #1;
        chk_out("r.async", 0, 0, 0);
        chk("r.aslot", int'(active_slot), 0);
        #3 reset = 1'b0;
        set_time(1, 2, 0, 0, 0, 0);
        tick();
        chk_out("r.cleared", 0, 0, 0);
        tick();
        chk("r.cleared2", int'(alarm), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
